output_port_arbiter: RTL and testbench

Output-side arbiter for one router output port (N, S, E, W or PE). It collects request/packet pairs from the routing units of the other input ports and grants them by fixed time-slot round robin. Accepted packets go into a small first-word-fall-through (FWFT) buffer, which drives the outgoing link with a valid/ready handshake. Each requester sees a per-port `full` signal; it issues `req` only while its `full` is low, and the packet is then taken on that same edge.

---
 rtl/output_port_arbiter.sv | 76 +++++++
 tb/tb_output_port_arbiter.sv | 218 +++++++++++++++++++++
 2 files changed

// File: rtl/output_port_arbiter.sv
// Output-side arbiter for one router port: fixed time-slot round robin over the
// routing units, feeding a small FWFT buffer that drives a valid/ready link.
module output_port_arbiter #(
  parameter int NUM_IN = 4,
  parameter int DATA_W = 64,
  parameter int DEPTH  = 4
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [NUM_IN-1:0]        req_in,
  input  logic [NUM_IN*DATA_W-1:0] packet_in,
  output logic [NUM_IN-1:0]        full_out,
  output logic [DATA_W-1:0]        out_packet,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     err_req
);

  localparam int SLOT_W = (NUM_IN > 1) ? $clog2(NUM_IN) : 1;
  localparam int PTR_W  = $clog2(DEPTH);
  localparam int CNT_W  = PTR_W + 1;
  localparam logic [SLOT_W-1:0] SLOT_LAST = SLOT_W'(NUM_IN - 1);
  localparam logic [CNT_W-1:0]  CNT_FULL  = CNT_W'(DEPTH);

  logic [SLOT_W-1:0] slot;
  logic [PTR_W-1:0]  wr_ptr;
  logic [PTR_W-1:0]  rd_ptr;
  logic [DATA_W-1:0] mem [DEPTH];
  logic              buf_full;
  logic              push;
  logic              pop;
  logic              illegal;

  // full_out depends only on registered slot/count so req can never loop back into it
  assign buf_full = (count == CNT_FULL);

  always_comb begin
    full_out = '1;
    for (int i = 0; i < NUM_IN; i++) begin
      full_out[i] = (slot != SLOT_W'(i)) || buf_full;
    end
  end

  assign push       = req_in[slot] && !buf_full;
  assign illegal    = |(req_in & full_out);
  assign out_valid  = (count != '0);
  assign pop        = out_valid && out_ready;
  assign out_packet = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (reset) begin
      slot    <= '0;
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count   <= '0;
      err_req <= 1'b0;
    end else begin
      slot <= (slot == SLOT_LAST) ? '0 : slot + 1'b1;
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
      if (illegal) err_req <= 1'b1;
    end
  end

  // Storage is not reset; contents are don't-care while out_valid is low
  always_ff @(posedge clk) begin
    if (push && !reset) mem[wr_ptr] <= packet_in[slot*DATA_W +: DATA_W];
  end

endmodule

// File: tb/tb_output_port_arbiter.sv
// Scoreboard bench for output_port_arbiter: stimulus pushes expected packets,
// a negedge monitor pops and compares whenever the link hands a packet over.
module tb_output_port_arbiter;
  localparam int NUM_IN = 4;
  localparam int DATA_W = 64;
  localparam int DEPTH  = 4;

  logic         clk = 1'b0;
  logic         reset = 1'b1;
  logic [3:0]   req_in = '0;
  logic [255:0] packet_in = '0;
  logic [3:0]   full_out;
  logic [63:0]  out_packet;
  logic         out_valid;
  logic         out_ready = 1'b0;
  logic [2:0]   count;
  logic         err_req;

  output_port_arbiter #(.NUM_IN(NUM_IN), .DATA_W(DATA_W), .DEPTH(DEPTH)) dut (
    .clk(clk), .reset(reset), .req_in(req_in), .packet_in(packet_in),
    .full_out(full_out), .out_packet(out_packet), .out_valid(out_valid),
    .out_ready(out_ready), .count(count), .err_req(err_req)
  );

  always #5 clk = ~clk;

  int          vectors = 0;
  int          miscompares = 0;
  int          pops = 0;
  logic [63:0] exp_q[$];
  logic [63:0] hold_pkt[4];
  bit          hold[4];
  int          mslot = 0;
  int          mcount = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (!reset && out_valid && out_ready) begin
      pops++;
      if (exp_q.size() == 0) begin
        vectors++;
        miscompares++;
        $display("FAIL unexpected_pop: got %0h, expected no packet", out_packet);
      end else begin
        check("out_packet_order", out_packet, exp_q.pop_front());
      end
    end
  end

  function automatic bit any_hold();
    return hold[0] | hold[1] | hold[2] | hold[3];
  endfunction

  // One clock: check state, drive requesters that obey full, predict accept/pop
  task automatic cycle(input logic rdy);
    logic [3:0] mfull;
    bit acc;
    bit pp;
    for (int i = 0; i < 4; i++) mfull[i] = (mslot != i) || (mcount == DEPTH);
    check("full_out", full_out, mfull);
    check("count", count, mcount);
    check("out_valid", out_valid, mcount != 0);
    for (int i = 0; i < 4; i++) begin
      req_in[i] = hold[i] && !mfull[i];
      packet_in[i*64 +: 64] = hold_pkt[i];
    end
    out_ready = rdy;
    acc = hold[mslot] && !mfull[mslot];
    if (acc) begin
      exp_q.push_back(hold_pkt[mslot]);
      hold[mslot] = 0;
    end
    pp = (mcount != 0) && rdy;
    @(posedge clk);
    #1;
    req_in = '0;
    mcount = mcount + int'(acc) - int'(pp);
    mslot = (mslot + 1) % NUM_IN;
  endtask

  task automatic do_reset(input int cycles);
    reset = 1'b1;
    req_in = '0;
    out_ready = 1'b0;
    repeat (cycles) @(posedge clk);
    #1;
    reset = 1'b0;
    mslot = 0;
    mcount = 0;
    exp_q.delete();
    for (int i = 0; i < 4; i++) hold[i] = 0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, expected summary first");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [3:0] seq[5] = '{4'b1110, 4'b1101, 4'b1011, 4'b0111, 4'b1110};
    int pops_before;
    int issued;
    int maxc;

    // Reset values and slot rotation
    do_reset(2);
    check("rst_count", count, 0);
    check("rst_valid", out_valid, 0);
    check("rst_err", err_req, 0);
    for (int k = 0; k < 5; k++) begin
      check("rst_full_seq", full_out, seq[k]);
      cycle(1'b0);
    end

    // Single packet from requester 2
    hold_pkt[2] = 64'hA5A5_0000_0000_0001;
    hold[2] = 1;
    for (int n = 0; n < NUM_IN && hold[2]; n++) cycle(1'b1);
    check("single_valid", out_valid, 1);
    check("single_data", out_packet, 64'hA5A5_0000_0000_0001);
    check("single_count", count, 1);
    cycle(1'b1);
    check("single_drain", count, 0);

    // Contention from slot 0
    for (int n = 0; n < NUM_IN && mslot != 0; n++) cycle(1'b1);
    pops_before = pops;
    for (int i = 0; i < 4; i++) begin
      hold_pkt[i] = 64'(i + 1);
      hold[i] = 1;
    end
    for (int k = 1; k <= 4; k++) begin
      cycle(1'b1);
      check("contention_head", out_packet, 64'(k));
      check("contention_count", count, 1);
    end
    cycle(1'b1);
    check("contention_pops", pops - pops_before, 4);

    // Back-pressure
    for (int i = 0; i < 4; i++) begin
      hold_pkt[i] = 64'h10 + 64'(i);
      hold[i] = 1;
    end
    repeat (4) cycle(1'b0);
    check("bp_count_full", count, 4);
    check("bp_full_out", full_out, 4'b1111);
    for (int i = 0; i < 4; i++) begin
      hold_pkt[i] = 64'h20 + 64'(i);
      hold[i] = 1;
    end
    repeat (2) cycle(1'b0);
    check("bp_no_write", count, 4);
    cycle(1'b1);
    check("bp_one_pop", count, 3);
    cycle(1'b0);
    check("bp_next_accept", count, 4);
    for (int n = 0; n < 40 && (mcount != 0 || any_hold()); n++) cycle(1'b1);
    check("bp_drained", count, 0);

    // Wrap with toggling ready
    pops_before = pops;
    issued = 0;
    maxc = 0;
    for (int n = 0; n < 80 && (issued < 10 || any_hold() || mcount != 0); n++) begin
      for (int i = 0; i < 4; i++) begin
        if (!hold[i] && issued < 10) begin
          hold_pkt[i] = 64'h100 + 64'(issued);
          hold[i] = 1;
          issued++;
        end
      end
      cycle((n % 2) == 0);
      if (int'(count) > maxc) maxc = int'(count);
    end
    check("wrap_max_count", maxc, 4);
    check("wrap_pops", pops - pops_before, 10);
    check("wrap_queue_empty", exp_q.size(), 0);
    check("wrap_no_err", err_req, 0);

    // Protocol violation, then reset with a partly full buffer
    for (int n = 0; n < NUM_IN && mslot != 3; n++) cycle(1'b0);
    out_ready = 1'b0;
    req_in = 4'b0010;
    packet_in[64 +: 64] = 64'hDEAD_BEEF;
    @(posedge clk);
    #1;
    req_in = '0;
    mslot = (mslot + 1) % NUM_IN;
    check("viol_err", err_req, 1);
    check("viol_no_write", count, 0);
    check("viol_no_valid", out_valid, 0);
    for (int i = 0; i < 3; i++) begin
      hold_pkt[i] = 64'h30 + 64'(i);
      hold[i] = 1;
    end
    for (int n = 0; n < 12 && mcount < 3; n++) cycle(1'b0);
    check("mid_count3", count, 3);
    check("err_sticky", err_req, 1);
    do_reset(1);
    check("mid_rst_count", count, 0);
    check("mid_rst_valid", out_valid, 0);
    check("mid_rst_err", err_req, 0);
    check("mid_rst_full", full_out, 4'b1110);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
